// File: rtl/avalon_row_reader.sv
// Avalon-MM read master: fetches num_rows consecutive 64-bit rows into a small FIFO and streams them out.
// Optional watchdog on read data, enabled by defining READ_TIMEOUT_EN.
module avalon_row_reader #(
    parameter  int unsigned FIFO_DEPTH     = 4,
    parameter  int unsigned MAX_ROWS       = 8,
    parameter  int unsigned ADDR_STRIDE    = 1,
    parameter  int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned IDX_W          = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [3:0]       num_rows,
    output logic [31:0]      address,
    output logic             read,
    input  logic [63:0]      readdata,
    input  logic             readdatavalid,
    input  logic             waitrequest,
    output logic [63:0]      row_data,
    output logic [IDX_W-1:0] row_idx,
    output logic             row_valid,
    input  logic             row_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DATA,
        S_STALL,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        base_q, base_d;
    logic [3:0]         rows_q, rows_d;
    logic [31:0]        address_q, address_d;
    logic               read_q, busy_q, done_q, done_d;

    logic [63:0]        mem_data_q [FIFO_DEPTH];
    logic [IDX_W-1:0]   mem_idx_q  [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, cnt_post;

    logic push, pop, flush, last_row, job_start, tmo_hit;

    assign row_valid = (count_q != '0);
    assign pop       = row_valid && row_ready;
    assign row_data  = mem_data_q[rd_ptr_q];
    assign row_idx   = mem_idx_q[rd_ptr_q];
    assign address   = address_q;
    assign read      = read_q;
    assign busy      = busy_q;
    assign done      = done_q;

    assign last_row  = (32'(idx_q) + 32'd1 == 32'(rows_q));
    assign cnt_post  = count_q + CNT_W'(1) - CNT_W'(pop);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        rows_d    = rows_q;
        done_d    = 1'b0;
        push      = 1'b0;
        flush     = 1'b0;
        job_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    job_start = 1'b1;
                    base_d    = base_addr;
                    rows_d    = num_rows;
                    idx_d     = '0;
                    if (num_rows != 4'd0) state_d = S_ISSUE;
                    else                  done_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!waitrequest) state_d = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (readdatavalid) begin
                    push = 1'b1;
                    if (last_row) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        // Only re-issue when a slot is guaranteed free for the next beat
                        state_d = (cnt_post < CNT_W'(FIFO_DEPTH)) ? S_ISSUE : S_STALL;
                    end
                end else if (tmo_hit) begin
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_STALL: begin
                if (count_q < CNT_W'(FIFO_DEPTH)) state_d = S_ISSUE;
            end
            S_DRAIN: begin
                if (count_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign address_d = base_d + 32'(idx_d) * 32'(ADDR_STRIDE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            rows_q    <= '0;
            address_q <= '0;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            rows_q    <= rows_d;
            address_q <= address_d;
            read_q    <= (state_d == S_ISSUE);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_idx_q[i]  <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= readdata;
                mem_idx_q[wr_ptr_q]  <= idx_q;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef READ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign tmo_hit = (state_q == S_WAIT_DATA) && !readdatavalid &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_WAIT_DATA && !readdatavalid && !tmo_hit) tmo_q <= tmo_q + TMO_W'(1);
            else                                                      tmo_q <= '0;
            if (job_start)    err_q <= 1'b0;
            else if (tmo_hit) err_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit    = 1'b0;
    assign err        = 1'b0;
    assign unused_cfg = ^{job_start, 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_avalon_row_reader.sv
// Directed bench for avalon_row_reader: behavioural Avalon slave with ROM, stream scoreboard, job scenarios.
// Timeout scenario runs only when READ_TIMEOUT_EN is defined.
module tb_avalon_row_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [3:0]  num_rows = '0;
    logic [31:0] address;
    logic        read;
    logic [63:0] readdata = '0;
    logic        readdatavalid = 1'b0;
    logic        waitrequest = 1'b0;
    logic [63:0] row_data;
    logic [2:0]  row_idx;
    logic        row_valid;
    logic        row_ready = 1'b1;
    logic        busy, done, err;

    avalon_row_reader #(
        .FIFO_DEPTH(4), .MAX_ROWS(8), .ADDR_STRIDE(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .address(address), .read(read), .readdata(readdata), .readdatavalid(readdatavalid),
        .waitrequest(waitrequest), .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
        .row_ready(row_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rom(input logic [31:0] a);
        return {32'hC0DE_0000 ^ a, ~a};
    endfunction

    // Slave: one outstanding read, response `lat` edges after accept
    int          lat = 3;
    bit          respond = 1'b1;
    bit          stray = 1'b0;
    logic [31:0] hold_addr = 32'hFFFF_FFF0;
    int          hold_n = 0;
    int          hold_used = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          acc_cyc = 0;
    logic [31:0] acc_addr[$];
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    always @(posedge clk) begin
        bit          acc;
        bit          resp_v;
        logic [31:0] a;
        cyc++;
        acc = read && !waitrequest;
        a   = address;
        if (acc) begin
            acc_cnt++;
            acc_cyc = cyc;
            acc_addr.push_back(a);
        end
        #1;
        resp_v = 1'b0;
        if (acc) begin
            pend  = respond;
            cnt   = lat;
            paddr = a;
        end else if (pend) begin
            cnt--;
            if (cnt <= 0) begin
                resp_v = 1'b1;
                pend   = 1'b0;
            end
        end
        readdata      = resp_v ? rom(paddr) : 64'hBAD0_BAD0_BAD0_BAD0;
        readdatavalid = resp_v || stray;
        waitrequest   = read && (address == hold_addr) && (hold_used < hold_n);
        if (waitrequest) hold_used++;
    end

    // Stream scoreboard and event counters
    logic [31:0] exp_base = '0;
    int          job_pop0 = 0;
    int          pops = 0;
    int          done_cnt = 0;
    int          done_at = 0;
    int          pops_at_done = 0;
    int          valid_cyc = 0;
    int          wr_cyc = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (row_valid && row_ready) begin
                check("row_idx", 64'(row_idx), 64'(pops - job_pop0));
                check("row_data", row_data, rom(exp_base + 32'(pops - job_pop0)));
                pops++;
            end
            if (done) begin
                done_cnt++;
                done_at      = cyc;
                pops_at_done = pops;
                check("busy_low_at_done", 64'(busy), 64'd0);
            end
            if (row_valid) valid_cyc++;
            if (read && waitrequest) begin
                wr_cyc++;
                check("addr_held", 64'(address), 64'(hold_addr));
            end
        end
    end

    task automatic do_start(input logic [31:0] b, input logic [3:0] n);
        @(posedge clk); #1;
        base_addr = b;
        num_rows  = n;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int i  = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input string tag, input int target, input int budget);
        int i = 0;
        while (acc_cnt < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        check({tag, "_accept_seen"}, 64'(acc_cnt >= target), 64'd1);
        #1;
    endtask

    initial begin
        int a0, p0, d0, v0, w0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", 64'(read), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_row_valid", 64'(row_valid), 64'd0);
        check("rst_row_data", row_data, 64'd0);
        check("rst_row_idx", 64'(row_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset_n = 1'b1;

        // 8 rows, long latency, consumer always ready
        lat = 12; row_ready = 1'b1; exp_base = 32'd0;
        a0 = acc_cnt; p0 = pops; d0 = done_cnt; job_pop0 = pops;
        do_start(32'd0, 4'd8);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        check("t1_read_after_start", 64'(read), 64'd1);
        wait_done("t1", 400);
        check("t1_accepts", 64'(acc_cnt - a0), 64'd8);
        for (int k = 0; k < 8; k++) check("t1_addr", 64'(acc_addr[a0 + k]), 64'(k));
        check("t1_pops", 64'(pops - p0), 64'd8);
        check("t1_pops_before_done", 64'(pops_at_done - p0), 64'd8);
        check("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_err", 64'(err), 64'd0);

        // Consumer stalled: credit limit of 4 reads
        lat = 2; row_ready = 1'b0; exp_base = 32'd100;
        a0 = acc_cnt; p0 = pops; job_pop0 = pops;
        do_start(32'd100, 4'd8);
        repeat (40) @(posedge clk);
        #1;
        check("t2_accepts_stalled", 64'(acc_cnt - a0), 64'd4);
        check("t2_read_stalled", 64'(read), 64'd0);
        check("t2_row_valid", 64'(row_valid), 64'd1);
        check("t2_head_idx", 64'(row_idx), 64'd0);
        row_ready = 1'b1;
        wait_done("t2", 200);
        check("t2_accepts", 64'(acc_cnt - a0), 64'd8);
        for (int k = 0; k < 8; k++) check("t2_addr", 64'(acc_addr[a0 + k]), 64'(100 + k));
        check("t2_pops", 64'(pops - p0), 64'd8);

        // waitrequest held on row 2
        lat = 3; hold_addr = 32'h22; hold_n = 5; exp_base = 32'h20;
        a0 = acc_cnt; p0 = pops; w0 = wr_cyc; job_pop0 = pops;
        do_start(32'h20, 4'd4);
        wait_done("t3", 200);
        check("t3_wait_cycles", 64'(wr_cyc - w0), 64'd5);
        check("t3_accepts", 64'(acc_cnt - a0), 64'd4);
        check("t3_addr_row2", 64'(acc_addr[a0 + 2]), 64'h22);
        check("t3_pops", 64'(pops - p0), 64'd4);
        hold_addr = 32'hFFFF_FFF0;

        // num_rows == 0
        a0 = acc_cnt;
        @(posedge clk); #1;
        num_rows = 4'd0; base_addr = 32'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_done", 64'(done), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_read", 64'(read), 64'd0);
        @(posedge clk); #1;
        check("t4_done_pulse", 64'(done), 64'd0);
        check("t4_busy2", 64'(busy), 64'd0);
        check("t4_no_accept", 64'(acc_cnt - a0), 64'd0);

        // start while busy is ignored
        lat = 4; exp_base = 32'h40;
        a0 = acc_cnt; p0 = pops; d0 = done_cnt; job_pop0 = pops;
        do_start(32'h40, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        base_addr = 32'h99; num_rows = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_busy_mid", 64'(busy), 64'd1);
        wait_done("t5", 200);
        repeat (5) @(posedge clk);
        #1;
        check("t5_accepts", 64'(acc_cnt - a0), 64'd3);
        for (int k = 0; k < 3; k++) check("t5_addr", 64'(acc_addr[a0 + k]), 64'(32'h40 + k));
        check("t5_pops", 64'(pops - p0), 64'd3);
        check("t5_done_once", 64'(done_cnt - d0), 64'd1);
        check("t5_busy_end", 64'(busy), 64'd0);

        // Reset while waiting for data, then stray readdatavalid
        lat = 20; exp_base = 32'h50;
        a0 = acc_cnt; job_pop0 = pops;
        do_start(32'h50, 4'd4);
        wait_acc("t5r", a0 + 1, 50);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5r_read", 64'(read), 64'd0);
        check("t5r_busy", 64'(busy), 64'd0);
        check("t5r_address", 64'(address), 64'd0);
        check("t5r_row_valid", 64'(row_valid), 64'd0);
        check("t5r_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        v0 = valid_cyc; d0 = done_cnt;
        repeat (4) @(posedge clk);
        #2;
        stray = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        stray = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("t5r_no_valid", 64'(valid_cyc - v0), 64'd0);
        check("t5r_no_done", 64'(done_cnt - d0), 64'd0);
        check("t5r_busy_after", 64'(busy), 64'd0);
        check("t5r_read_after", 64'(read), 64'd0);

`ifdef READ_TIMEOUT_EN
        // Slave never answers: watchdog fires 16 cycles after accept
        respond = 1'b0;
        a0 = acc_cnt; p0 = pops; d0 = done_cnt; job_pop0 = pops; exp_base = 32'h60;
        do_start(32'h60, 4'd2);
        wait_acc("t6", a0 + 1, 50);
        wait_done("t6", 60);
        check("t6_done_delay", 64'(done_at - acc_cyc), 64'd16);
        check("t6_err", 64'(err), 64'd1);
        check("t6_row_valid", 64'(row_valid), 64'd0);
        check("t6_pops", 64'(pops - p0), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        respond = 1'b1;
        do_start(32'd0, 4'd0);
        check("t6_err_cleared", 64'(err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
